s1494_state_step: RTL
=====================

S1494_STATE_STEP -- requirements
Module: s1494_state_step

Interface
REQ-001 SHALL have parameter SETTLE, default 1, number of EVAL cycles allowed for the downstream next-state slices to settle (legal 1..15).
REQ-002 SHALL have parameter CNT_W, default 16, width of the step counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port CLR  input  1  functional clear, active-low, sampled only at COMMIT.
REQ-006 SHALL have port pi_in  input  7  primary inputs v0..v6, bit i = vi.
REQ-007 SHALL have port pi_valid  input  1  pi_in offered this cycle.
REQ-008 SHALL have port pi_ready  output  1  block accepts pi_in this cycle.
REQ-009 SHALL have port hold  input  1  freezes the settle counter while in EVAL.
REQ-010 SHALL have port ns_in  input  6  next-state bits from the slice netlists; bit 0 = n65 (next v7), bits 1..5 = next v8..v12.
REQ-011 SHALL have port pi_q  output  7  registered v0..v6 driven to the slices.
REQ-012 SHALL have port ps_out  output  6  present state; bit 0 = v7 ... bit 5 = v12.
REQ-013 SHALL have port step_done  output  1  one-cycle pulse on each commit.
REQ-014 SHALL have port step_cnt  output  CNT_W  number of commits since reset.
REQ-015 SHALL have port busy  output  1  high in EVAL or COMMIT.

Function
REQ-016 SHALL implement a three-state machine: IDLE, EVAL, COMMIT.
REQ-017 SHALL drive pi_ready = 1 only in IDLE; busy = not IDLE.
REQ-018 In IDLE, on pi_valid=1, SHALL load pi_q <= pi_in, load settle counter with SETTLE, and go to EVAL next cycle.
REQ-019 In IDLE, with pi_valid=0, SHALL hold all registers.
REQ-020 In EVAL, with hold=0, SHALL decrement the settle counter each cycle; on the cycle it reaches 1, SHALL go to COMMIT next.
REQ-021 In EVAL, with hold=1, SHALL keep counter and state unchanged; pi_q SHALL remain stable throughout EVAL and COMMIT.
REQ-022 In COMMIT, SHALL load ps_out <= ns_in when CLR=1, and ps_out <= 6'b000000 when CLR=0; CLR=0 SHALL take priority over ns_in.
REQ-023 In COMMIT, SHALL pulse step_done=1 for exactly that cycle and increment step_cnt modulo 2^CNT_W (wrap to 0 with no flag).
REQ-024 COMMIT SHALL last exactly one cycle and return to IDLE; a pi_valid arriving in COMMIT SHALL NOT be accepted until IDLE.
REQ-025 Latency from pi_valid accepted in IDLE to step_done SHALL be SETTLE+1 cycles with hold=0; throughput is one step per SETTLE+2 cycles.
REQ-026 ps_out SHALL change only in COMMIT or on reset; pi_q SHALL change only on an IDLE accept or on reset.
REQ-027 SETTLE outside 1..15 SHALL be a compile-time error.

Reset
REQ-028 With RST=1 at a clock edge, SHALL set state=IDLE, pi_q=0, ps_out=0, step_cnt=0, step_done=0, and the settle counter to 0, overriding all other inputs.
REQ-029 RST asserted in EVAL or COMMIT SHALL abort the step: no step_done and no ps_out/step_cnt update from that step.
REQ-030 The first cycle after RST deasserts SHALL be IDLE with pi_ready=1.

Verification
REQ-031 Reset then single step: SETTLE=1, pi_in=7'h55 with pi_valid for 1 cycle, ns_in=6'h2A, CLR=1 -> pi_q=7'h55 next cycle, step_done at cycle +2, ps_out=6'h2A, step_cnt=1.
REQ-032 Functional clear: ns_in=6'h3F, CLR=0 at COMMIT -> ps_out=6'h00, step_done still pulses, step_cnt increments.
REQ-033 Hold stretch: SETTLE=3, hold=1 for 4 cycles mid-EVAL -> step_done at 3+4+1 = 8 cycles after accept; pi_q unchanged throughout.
REQ-034 Back-to-back: pi_valid held high continuously with SETTLE=1 -> accepts every 3 cycles, pi_ready=0 in EVAL/COMMIT, no input lost or double-counted.
REQ-035 Reset mid-step: RST in EVAL -> ps_out=0, step_cnt=0, no step_done, IDLE next cycle.
REQ-036 Counter wrap: CNT_W=4, 16 commits -> step_cnt returns to 0 with no other side effect.

Source files
------------

// File: rtl/s1494_state_step.sv
// Sequencer for the s1494 state slices: latches primary inputs, waits SETTLE
// cycles for the next-state slices to settle, then commits ns_in into the state register.
module s1494_state_step #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic [6:0]       pi_in,
  input  logic             pi_valid,
  output logic             pi_ready,
  input  logic             hold,
  input  logic [5:0]       ns_in,
  output logic [6:0]       pi_q,
  output logic [5:0]       ps_out,
  output logic             step_done,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("s1494_state_step: SETTLE must be in 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("s1494_state_step: CNT_W must be at least 1");
  end

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_COMMIT
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [6:0]       pi_q_q, pi_q_d;
  logic [5:0]       ps_q, ps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      pi_q_q   <= '0;
      ps_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      pi_q_q   <= pi_q_d;
      ps_q     <= ps_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    pi_q_d   = pi_q_q;
    ps_d     = ps_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pi_valid) begin
          pi_q_d   = pi_in;
          settle_d = SETTLE_INIT;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        // hold freezes both the count and the exit decision
        if (!hold) begin
          settle_d = settle_q - 4'd1;
          if (settle_q == 4'd1) begin
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        ps_d    = CLR ? ns_in : '0;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pi_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign step_done = (state_q == S_COMMIT);
  assign pi_q      = pi_q_q;
  assign ps_out    = ps_q;
  assign step_cnt  = cnt_q;

endmodule
